// File: rtl/fn1_mac_pipe_param_if.sv
// rtl/fn1_mac_pipe_param_if.sv - operand/control and result bundle for the pipelined MAC
interface fn1_mac_pipe_param_if #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 16,
    parameter int DOUT_WIDTH = 32
);
    logic                  ce;
    logic                  in_valid;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  signed_mode;
    logic                  acc_en;
    logic                  acc_clr;
    logic                  out_valid;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  sat_flag;

    modport master (
        output ce, in_valid, din0, din1, signed_mode, acc_en, acc_clr,
        input  out_valid, dout, sat_flag
    );

    modport slave (
        input  ce, in_valid, din0, din1, signed_mode, acc_en, acc_clr,
        output out_valid, dout, sat_flag
    );
endinterface

// File: rtl/fn1_mac_pipe_param.sv
// rtl/fn1_mac_pipe_param.sv - pipelined signed/unsigned multiply-accumulate with saturation
module fn1_mac_pipe_param #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int DOUT_WIDTH = 32,
    parameter int NUM_STAGE  = 4
) (
    input  logic                clk,
    input  logic                reset,
    fn1_mac_pipe_param_if.slave bus
);
    localparam int MD = NUM_STAGE - 2;
    localparam logic [ACC_WIDTH-1:0] ACC_UMAX = '1;
    localparam logic [ACC_WIDTH-1:0] ACC_SMAX = ACC_UMAX >> 1;
    localparam logic [ACC_WIDTH-1:0] ACC_SMIN = ~ACC_SMAX;
    localparam logic [ACC_WIDTH-1:0] OUT_UMAX = ACC_UMAX >> (ACC_WIDTH - DOUT_WIDTH);
    localparam logic [ACC_WIDTH-1:0] OUT_SMAX = ACC_UMAX >> (ACC_WIDTH - DOUT_WIDTH + 1);
    localparam logic [ACC_WIDTH-1:0] OUT_SMIN = ~OUT_SMAX;

    logic                  s1_valid, s1_sm, s1_en, s1_clr;
    logic [DIN0_WIDTH-1:0] s1_a;
    logic [DIN1_WIDTH-1:0] s1_b;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_sm    <= 1'b0;
            s1_en    <= 1'b0;
            s1_clr   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (bus.ce) begin
            s1_valid <= bus.in_valid;
            s1_sm    <= bus.signed_mode;
            s1_en    <= bus.acc_en;
            s1_clr   <= bus.acc_clr;
            s1_a     <= bus.din0;
            s1_b     <= bus.din1;
        end
    end

    // Operands are extended to the accumulator width first; since ACC_WIDTH covers the
    // full product, the modulo-2^ACC product is already the correctly extended result.
    logic [ACC_WIDTH-1:0] a_ext, b_ext, prod;

    always_comb begin
        a_ext = s1_sm ? ACC_WIDTH'($signed(s1_a)) : ACC_WIDTH'(s1_a);
        b_ext = s1_sm ? ACC_WIDTH'($signed(s1_b)) : ACC_WIDTH'(s1_b);
        prod  = a_ext * b_ext;
    end

    logic [ACC_WIDTH-1:0] m_prod [MD];
    logic [MD-1:0]        m_valid, m_sm, m_en, m_clr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MD; i++) m_prod[i] <= '0;
            m_valid <= '0;
            m_sm    <= '0;
            m_en    <= '0;
            m_clr   <= '0;
        end else if (bus.ce) begin
            m_prod[0]  <= prod;
            m_valid[0] <= s1_valid;
            m_sm[0]    <= s1_sm;
            m_en[0]    <= s1_en;
            m_clr[0]   <= s1_clr;
            for (int i = 1; i < MD; i++) begin
                m_prod[i]  <= m_prod[i-1];
                m_valid[i] <= m_valid[i-1];
                m_sm[i]    <= m_sm[i-1];
                m_en[i]    <= m_en[i-1];
                m_clr[i]   <= m_clr[i-1];
            end
        end
    end

    logic                  f_valid, f_sm, f_en, f_clr, restart, acc_clip, out_clip;
    logic                  prev_sm;
    logic [ACC_WIDTH-1:0]  acc, f_prod, base, acc_next;
    logic [ACC_WIDTH:0]    sum;
    logic [DOUT_WIDTH-1:0] dout_next;

    always_comb begin
        f_valid   = m_valid[MD-1];
        f_sm      = m_sm[MD-1];
        f_en      = m_en[MD-1];
        f_clr     = m_clr[MD-1];
        f_prod    = m_prod[MD-1];
        // A mode change mid-accumulation cannot be meaningfully summed, so it restarts.
        restart   = !f_en || f_clr || (f_sm != prev_sm);
        base      = restart ? '0 : acc;
        acc_clip  = 1'b0;
        out_clip  = 1'b0;
        if (f_sm) begin
            sum      = {base[ACC_WIDTH-1], base} + {f_prod[ACC_WIDTH-1], f_prod};
            acc_next = sum[ACC_WIDTH-1:0];
            if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
                acc_clip = 1'b1;
                acc_next = sum[ACC_WIDTH] ? ACC_SMIN : ACC_SMAX;
            end
            if ($signed(acc_next) > $signed(OUT_SMAX)) begin
                out_clip  = 1'b1;
                dout_next = OUT_SMAX[DOUT_WIDTH-1:0];
            end else if ($signed(acc_next) < $signed(OUT_SMIN)) begin
                out_clip  = 1'b1;
                dout_next = OUT_SMIN[DOUT_WIDTH-1:0];
            end else begin
                dout_next = acc_next[DOUT_WIDTH-1:0];
            end
        end else begin
            sum      = {1'b0, base} + {1'b0, f_prod};
            acc_next = sum[ACC_WIDTH-1:0];
            if (sum[ACC_WIDTH]) begin
                acc_clip = 1'b1;
                acc_next = ACC_UMAX;
            end
            if (acc_next > OUT_UMAX) begin
                out_clip  = 1'b1;
                dout_next = OUT_UMAX[DOUT_WIDTH-1:0];
            end else begin
                dout_next = acc_next[DOUT_WIDTH-1:0];
            end
        end
    end

    // Bubbles clear out_valid but leave the accumulator and visible result untouched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc          <= '0;
            prev_sm      <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.dout     <= '0;
            bus.sat_flag <= 1'b0;
        end else if (bus.ce) begin
            bus.out_valid <= f_valid;
            if (f_valid) begin
                acc          <= acc_next;
                prev_sm      <= f_sm;
                bus.dout     <= dout_next;
                bus.sat_flag <= acc_clip | out_clip;
            end
        end
    end
endmodule

// File: tb/tb_fn1_mac_pipe_param.sv
// tb/tb_fn1_mac_pipe_param.sv - directed vectors against a behavioural MAC model, two output widths
module tb_fn1_mac_pipe_param;
    localparam int W0 = 16, W1 = 16, AW = 40, DWA = 32, DWB = 16, NS = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fn1_mac_pipe_param_if #(.DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(DWA)) ifa();
    fn1_mac_pipe_param_if #(.DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(DWB)) ifb();

    fn1_mac_pipe_param #(.DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .ACC_WIDTH(AW),
                         .DOUT_WIDTH(DWA), .NUM_STAGE(NS))
        dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    fn1_mac_pipe_param #(.DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .ACC_WIDTH(AW),
                         .DOUT_WIDTH(DWB), .NUM_STAGE(NS))
        dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    typedef struct {
        bit v; bit sm; bit en; bit clr;
        logic [W0-1:0] a; logic [W1-1:0] b;
    } smp_t;
    typedef struct {
        int c; logic [DWA-1:0] da; logic sa; logic [DWB-1:0] db; logic sb;
    } obs_t;

    smp_t           pipe_q[$];
    obs_t           log_q[$];
    longint         m_acc;
    bit             m_prev;
    bit             exp_valid, exp_sa, exp_sb;
    logic [DWA-1:0] exp_da;
    logic [DWB-1:0] exp_db;
    int             cyc = 0;
    int             vectors = 0, errors = 0;
    bit             chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic longint clamp(input longint v, input bit sm, input int w, output bit clip);
        longint hi, lo;
        hi   = sm ? (64'sd1 <<< (w - 1)) - 1 : (64'sd1 <<< w) - 1;
        lo   = sm ? -(64'sd1 <<< (w - 1)) : 64'sd0;
        clip = (v > hi) || (v < lo);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic model_out(input smp_t s);
        longint pa, pb, o;
        bit ca, cla, clb;
        if (!s.v) begin
            exp_valid = 1'b0;
            return;
        end
        pa = s.sm ? longint'($signed(s.a)) : longint'(s.a);
        pb = s.sm ? longint'($signed(s.b)) : longint'(s.b);
        if (!s.en || s.clr || (s.sm != m_prev)) m_acc = pa * pb;
        else                                     m_acc = m_acc + pa * pb;
        m_acc  = clamp(m_acc, s.sm, AW, ca);
        m_prev = s.sm;
        o      = clamp(m_acc, s.sm, DWA, cla);
        exp_da = o[DWA-1:0];
        exp_sa = ca | cla;
        o      = clamp(m_acc, s.sm, DWB, clb);
        exp_db = o[DWB-1:0];
        exp_sb = ca | clb;
        exp_valid = 1'b1;
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            pipe_q.delete();
            m_acc = 0; m_prev = 1'b1;
            exp_valid = 1'b0; exp_sa = 1'b0; exp_sb = 1'b0; exp_da = '0; exp_db = '0;
        end else if (ifa.ce) begin
            pipe_q.push_back('{ifa.in_valid, ifa.signed_mode, ifa.acc_en, ifa.acc_clr, ifa.din0, ifa.din1});
            if (pipe_q.size() == NS) model_out(pipe_q.pop_front());
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid_a", ifa.out_valid, exp_valid);
            check("out_valid_b", ifb.out_valid, exp_valid);
            check("dout_a", ifa.dout, exp_da);
            check("sat_a", ifa.sat_flag, exp_sa);
            check("dout_b", ifb.dout, exp_db);
            check("sat_b", ifb.sat_flag, exp_sb);
            if (ifa.out_valid) log_q.push_back('{cyc, ifa.dout, ifa.sat_flag, ifb.dout, ifb.sat_flag});
        end
    end

    task automatic put(input bit c, input bit v, input bit sm, input bit en, input bit clr,
                       input logic [15:0] a, input logic [15:0] b);
        ifa.ce = c; ifa.in_valid = v; ifa.signed_mode = sm; ifa.acc_en = en; ifa.acc_clr = clr;
        ifa.din0 = a; ifa.din1 = b;
        ifb.ce = c; ifb.in_valid = v; ifb.signed_mode = sm; ifb.acc_en = en; ifb.acc_clr = clr;
        ifb.din0 = a; ifb.din1 = b;
        @(negedge clk);
    endtask

    task automatic flush(input int n);
        repeat (n) put(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Literal expectations for the oldest logged valid output; lat_from < 0 skips the latency check.
    task automatic expect_out(input string nm, input int lat_from, input logic [31:0] da, input bit sa,
                              input logic [15:0] db, input bit sb);
        obs_t o;
        if (log_q.size() == 0) begin
            vectors++; errors++;
            $display("FAIL %s: no valid output observed, expected dout %0h", nm, da);
            return;
        end
        o = log_q.pop_front();
        if (lat_from >= 0) check({nm, "_latency"}, o.c - lat_from, NS);
        check({nm, "_da"}, o.da, da);
        check({nm, "_sa"}, o.sa, sa);
        check({nm, "_db"}, o.db, db);
        check({nm, "_sb"}, o.sb, sb);
    endtask

    initial begin
        int t0;
        reset = 1'b0;
        put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk_en = 1'b1;
        put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        check("reset_out_valid", ifa.out_valid, 0);
        check("reset_dout", ifa.dout, 0);
        check("reset_sat", ifa.sat_flag, 0);
        reset = 1'b1;

        // plain multiply stream, back to back
        t0 = cyc;
        put(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 16'd4);
        put(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFE, 16'd5);
        put(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h8000, 16'h8000);
        flush(5);
        expect_out("mul0", t0,     32'd12,       1'b0, 16'd12,    1'b0);
        expect_out("mul1", t0 + 1, 32'hFFFFFFF6, 1'b0, 16'hFFF6,  1'b0);
        expect_out("mul2", t0 + 2, 32'h40000000, 1'b0, 16'h7FFF,  1'b1);

        // accumulate with clear
        put(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd2, 16'd3);
        put(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd4, 16'd5);
        put(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'd10);
        put(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 16'd1);
        flush(5);
        expect_out("acc0", -1, 32'd6,  1'b0, 16'd6,  1'b0);
        expect_out("acc1", -1, 32'd26, 1'b0, 16'd26, 1'b0);
        expect_out("acc2", -1, 32'd16, 1'b0, 16'd16, 1'b0);
        expect_out("acc3", -1, 32'd1,  1'b0, 16'd1,  1'b0);

        // output clipping, signed and unsigned
        put(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd200, 16'd200);
        put(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        flush(5);
        expect_out("sat0", -1, 32'd40000,    1'b0, 16'h7FFF, 1'b1);
        expect_out("sat1", -1, 32'hFFFE0001, 1'b0, 16'hFFFF, 1'b1);

        // ce stall of 5 cycles, then bubbles between accumulating samples
        t0 = cyc;
        put(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd5, 16'd6);
        repeat (5) put(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0077);
        put(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0100);
        put(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 16'd2);
        put(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0100);
        put(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0100);
        put(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd3, 16'd1);
        flush(5);
        expect_out("stall0", t0 + 5, 32'd30, 1'b0, 16'd30, 1'b0);
        expect_out("stall1", -1,     32'd32, 1'b0, 16'd32, 1'b0);
        expect_out("stall2", -1,     32'd35, 1'b0, 16'd35, 1'b0);

        // mode switch forces a restart
        put(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFD, 16'd3);
        put(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 16'd2);
        flush(5);
        expect_out("mode0", -1, 32'hFFFFFFF7, 1'b0, 16'hFFF7, 1'b0);
        expect_out("mode1", -1, 32'd4,        1'b0, 16'd4,    1'b0);

        // unsigned accumulation driven into the accumulator bound and held there
        repeat (270) put(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
        flush(5);
        while (log_q.size() > 1) void'(log_q.pop_front());
        expect_out("usat", -1, 32'hFFFFFFFF, 1'b1, 16'hFFFF, 1'b1);

        // reset with samples in flight, ce low during reset
        put(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd7, 16'd7);
        put(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 16'd1);
        put(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 16'd2);
        reset = 1'b0;
        put(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        check("rst_out_valid", ifa.out_valid, 0);
        check("rst_dout_a", ifa.dout, 0);
        check("rst_sat_a", ifa.sat_flag, 0);
        check("rst_dout_b", ifb.dout, 0);
        reset = 1'b1;
        flush(5);
        check("rst_no_leak", log_q.size(), 0);
        put(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 16'd2);
        flush(5);
        expect_out("post_rst", -1, 32'd4, 1'b0, 16'd4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
